lsu_mem_ctrl: RTL and testbench

Load/store initiator that sits between the MIPS-1 core's memory stage and the single-port, word-indexed data memory (combinational read, synchronous word write). It accepts one byte/halfword/word load or store at a time, converts the byte address to a word index, performs sign/zero extension on loads, and implements sub-word stores as read-modify-write, since the memory has no byte enables. Misaligned accesses are rejected without touching memory.

---
 rtl/lsu_mem_ctrl.sv | 140 ++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator between the core memory stage and a word-indexed single-port data memory.
// Sub-word stores are done as read-modify-write because the memory has no byte enables.
module lsu_mem_ctrl #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_uns_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              resp_valid_o,
  output logic [31:0]       resp_rdata_o,
  output logic              resp_err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  typedef enum logic [2:0] {StIdle, StLoad, StRmwRd, StWrite, StResp} state_e;

  state_e            state_q, state_d;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic [31:0]       resp_rdata_q;
  logic              resp_err_q;
  logic [31:0]       mem_wdata_q;

  logic        accept;
  logic        misaligned;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_ext;
  logic [31:0] merged;

  assign accept = req_valid_i & (state_q == StIdle);

  always_comb begin
    unique case (req_size_i)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr_i[0];
      2'b10:   misaligned = |req_addr_i[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (misaligned)               state_d = StResp;
          else if (!req_we_i)           state_d = StLoad;
          else if (req_size_i == 2'b10) state_d = StWrite;
          else                          state_d = StRmwRd;
        end
      end
      StLoad:  state_d = StResp;
      StRmwRd: state_d = StWrite;
      StWrite: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready_o  = (state_q == StIdle);
    mem_we_o     = (state_q == StWrite);
    resp_valid_o = (state_q == StResp);
    resp_err_o   = (state_q == StResp) & resp_err_q;
    resp_rdata_o = resp_rdata_q;
    mem_wdata_o  = mem_wdata_q;
    mem_addr_o   = {2'b00, addr_q[ADDR_W-1:2]};
  end

  // Lane selection and extension for loads, lane replacement for sub-word stores.
  always_comb begin
    ld_byte = mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
    ld_half = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    unique case (size_q)
      2'b00:   load_ext = {{24{~uns_q & ld_byte[7]}}, ld_byte};
      2'b01:   load_ext = {{16{~uns_q & ld_half[15]}}, ld_half};
      default: load_ext = mem_rdata_i;
    endcase
    merged = mem_rdata_i;
    if (size_q == 2'b00) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q;
    end else begin
      merged[15:0] = wdata_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_wdata_q  <= '0;
    end else begin
      if (accept) begin
        size_q       <= req_size_i;
        uns_q        <= req_uns_i;
        addr_q       <= req_addr_i;
        wdata_q      <= req_wdata_i[15:0];
        resp_rdata_q <= '0;
        resp_err_q   <= misaligned;
        // Word stores skip the read phase, so their write data is staged here.
        if (req_we_i && (req_size_i == 2'b10) && !misaligned) begin
          mem_wdata_q <= req_wdata_i;
        end
      end
      if (state_q == StLoad) begin
        resp_rdata_q <= load_ext;
      end
      if (state_q == StRmwRd) begin
        mem_wdata_q <= merged;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized self-checking bench for lsu_mem_ctrl against a word-array reference model.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_uns;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic        pre_en;
  logic [5:0]  pre_idx;
  logic [31:0] pre_val;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.ADDR_W(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_size_i   (req_size),
    .req_uns_i    (req_uns),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .resp_valid_o (resp_valid),
    .resp_rdata_o (resp_rdata),
    .resp_err_o   (resp_err),
    .mem_addr_o   (mem_addr),
    .mem_we_o     (mem_we),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[5:0]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
    else if (pre_en) mem[pre_idx] <= pre_val;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_word(input int idx, input logic [31:0] val);
    @(negedge clk);
    pre_en  = 1'b1;
    pre_idx = 6'(idx);
    pre_val = val;
    ref_mem[idx] = val;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  // Reference: expected response, latency and write for one request from the byte-level rules.
  function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                input logic [7:0] addr, input logic [31:0] wd,
                                output logic err, output logic [31:0] rd, output int lat,
                                output int wr_c, output logic [31:0] nw);
    int          off = int'(addr) % 4;
    int          idx = int'(addr) / 4;
    int          nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    logic [31:0] word = ref_mem[idx];
    logic [31:0] m = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    logic [31:0] v;
    err  = (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) || (size == 2'd2 && off != 0);
    rd   = 32'd0;
    wr_c = 0;
    nw   = word;
    if (err) begin
      lat = 1;
    end else if (!we) begin
      lat = 2;
      v = (word >> (8 * off)) & m;
      if (!uns && nb < 4 && v[8 * nb - 1]) v = v | ~m;
      rd = v;
    end else begin
      lat  = (nb == 4) ? 2 : 3;
      wr_c = lat - 1;
      nw   = (word & ~(m << (8 * off))) | ((wd & m) << (8 * off));
    end
  endfunction

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [7:0] addr, input logic [31:0] wd, input bit hold,
                        output logic [31:0] got);
    logic        e_err;
    logic [31:0] e_rd, e_nw, w_idx, w_dat;
    int          e_lat, e_wc, c, nwr, wc;
    model(we, size, uns, addr, wd, e_err, e_rd, e_lat, e_wc, e_nw);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_uns   = uns;
    req_addr  = {24'd0, addr};
    req_wdata = wd;
    check("ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    c = 0; nwr = 0; wc = 0; w_idx = '0; w_dat = '0; got = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) check("mem_addr", mem_addr, 32'(addr >> 2));
      check("ready_busy", 32'(req_ready), 32'd0);
      if (mem_we) begin
        nwr++; wc = i; w_idx = mem_addr; w_dat = mem_wdata;
      end
      if (resp_valid) begin
        c = i;
        got = resp_rdata;
        check("resp_err", 32'(resp_err), 32'(e_err));
        check("resp_rdata", resp_rdata, e_rd);
        break;
      end
    end
    check("latency", 32'(c), 32'(e_lat));
    check("write_count", 32'(nwr), (e_wc != 0) ? 32'd1 : 32'd0);
    if (e_wc != 0) begin
      check("write_cycle", 32'(wc), 32'(e_wc));
      check("write_idx", w_idx, 32'(addr >> 2));
      check("write_data", w_dat, e_nw);
      ref_mem[addr >> 2] = e_nw;
    end
    check("mem_word", mem[addr >> 2], ref_mem[addr >> 2]);
    if (!hold) req_valid = 1'b0;
  endtask

  logic [31:0] r;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_uns = 1'b0;
    req_addr = '0; req_wdata = '0; pre_en = 1'b0; pre_idx = '0; pre_val = '0;
    for (int i = 0; i < 64; i++) set_word(i, $urandom);
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;

    do_req(1'b1, 2'd2, 1'b0, 8'h10, 32'hDEADBEEF, 1'b0, r);
    do_req(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, 1'b0, r);
    check("lw_const", r, 32'hDEADBEEF);

    set_word(4, 32'h11223344);
    do_req(1'b1, 2'd0, 1'b0, 8'h12, 32'h000000AA, 1'b0, r);
    check("sb_merge_const", mem[4], 32'h11AA3344);
    do_req(1'b0, 2'd0, 1'b0, 8'h12, 32'h0, 1'b0, r);
    check("lb_const", r, 32'hFFFFFFAA);
    do_req(1'b0, 2'd0, 1'b1, 8'h12, 32'h0, 1'b0, r);
    check("lbu_const", r, 32'h000000AA);

    set_word(4, 32'h80017FFF);
    do_req(1'b0, 2'd1, 1'b0, 8'h10, 32'h0, 1'b0, r);
    check("lh_lo_const", r, 32'h00007FFF);
    do_req(1'b0, 2'd1, 1'b0, 8'h12, 32'h0, 1'b0, r);
    check("lh_hi_const", r, 32'hFFFF8001);
    do_req(1'b0, 2'd1, 1'b1, 8'h12, 32'h0, 1'b0, r);
    check("lhu_hi_const", r, 32'h00008001);

    do_req(1'b0, 2'd2, 1'b0, 8'h11, 32'h0, 1'b0, r);
    do_req(1'b1, 2'd1, 1'b0, 8'h13, 32'h12345678, 1'b0, r);
    do_req(1'b1, 2'd3, 1'b0, 8'h10, 32'h12345678, 1'b0, r);
    check("err_mem_const", mem[4], 32'h80017FFF);

    // Reset while a byte store sits in its read phase.
    set_word(5, 32'h55667788);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_uns = 1'b0;
    req_addr = 32'h15; req_wdata = 32'h000000CC;
    @(posedge clk);
    @(negedge clk);
    check("rmw_rd_no_we", 32'(mem_we), 32'd0);
    rst = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_we", 32'(mem_we), 32'd0);
    check("abort_resp", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_resp2", 32'(resp_valid), 32'd0);
    check("abort_we2", 32'(mem_we), 32'd0);
    check("abort_mem", mem[5], 32'h55667788);
    do_req(1'b0, 2'd2, 1'b0, 8'h14, 32'h0, 1'b0, r);

    // Back-to-back with req_valid held high throughout.
    do_req(1'b1, 2'd0, 1'b0, 8'h21, 32'h0000005A, 1'b1, r);
    do_req(1'b1, 2'd1, 1'b0, 8'h22, 32'h0000BEEF, 1'b1, r);
    do_req(1'b1, 2'd2, 1'b0, 8'h24, 32'hCAFEF00D, 1'b1, r);
    do_req(1'b0, 2'd2, 1'b0, 8'h20, 32'h0, 1'b1, r);
    do_req(1'b0, 2'd2, 1'b0, 8'h24, 32'h0, 1'b0, r);

    for (int n = 0; n < 300; n++) begin
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             8'($urandom_range(0, 255)), $urandom, bit'($urandom_range(0, 1)), r);
    end
    req_valid = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
